game_start_sequencer: RTL
=========================

Name: game_start_sequencer

Overview:
- Consumer end of the menu start handshake. Takes the menu's start trigger and game-mode selection, freezes the mode, and runs a 3-2-1 countdown, a "FIGHT" banner, the play phase and a game-over hold. It then hands control back to the menu.
- Sits between the menu and the fighter/arena logic.
- Drives menu_active, game_active, the latched mode, and two active-low seven-segment digits.

Parameters:
- COUNT_FRAMES, 60, frame_tick pulses per countdown digit.
- COUNT_START, 3, first countdown digit (1..9).
- FIGHT_FRAMES, 30, frame_tick pulses the "F" banner is shown.
- OVER_FRAMES, 120, frame_tick pulses held in game-over before returning to menu.
- CNT_W, 8, frame counter width; must hold max(COUNT_FRAMES, FIGHT_FRAMES, OVER_FRAMES).

Ports:
- clock  input  1  system clock.
- reset_n  input  1  synchronous, active-high reset; the port keeps the codebase name reset_n.
- frame_tick  input  1  one-clock pulse per video frame (60 Hz).
- trigger_count_start  input  1  level from menu; high while a confirm button is held.
- game_mode_chosen  input  1  1 = 2P, 0 = 1P.
- game_over  input  1  level from arena logic; a fighter's health reached zero.
- pause_btn  input  1  pause toggle request (used only with PAUSE_EN).
- menu_active  output  1  menu owns the display.
- game_active  output  1  fighters may move.
- mode_latched  output  1  mode frozen at trigger acceptance.
- seq_state  output  3  current state encoding, for debug and the display mux.
- hexout  output  7  active-low digit: countdown value, "F", or mode.
- hexout2  output  7  active-low digit: "P" in PLAY, blank otherwise.
- game_paused  output  1  play frozen (0 when PAUSE_EN is undefined).

Behaviour:
- Reset values:
  - state = IDLE, menu_active = 1, game_active = 0, mode_latched = 0.
  - hexout = hexout2 = 7'b1111111 (blank).
  - game_paused = 0, frame counter = 0, digit = 0, trigger history register = 1, so a held button is not seen as an edge.
- Trigger edge: a rising edge of trigger_count_start, detected on clock, is accepted only in IDLE. A level held across IDLE entry is ignored until it falls and rises again.
- IDLE:
  - On an accepted edge: latch mode_latched = game_mode_chosen, digit = COUNT_START, counter = 0, go to COUNT on the next clock.
  - menu_active drops in the same cycle as the transition.
- COUNT:
  - hexout shows the digit; counter increments only on frame_tick.
  - When counter == COUNT_FRAMES-1 and frame_tick: counter = 0, digit decrements.
  - When digit reaches 0, go to FIGHT instead.
- FIGHT: hexout = 7'b0001110 ("F") for FIGHT_FRAMES ticks, then PLAY.
- PLAY:
  - game_active = 1.
  - hexout = 1 (7'b1111001) or 2 (7'b0100100) per mode_latched; hexout2 = 7'b0001100 ("P").
  - game_over high moves to OVER on the next clock.
- OVER:
  - game_active = 0, digits blank.
  - After OVER_FRAMES ticks go to IDLE with menu_active = 1.
- Ignored inputs: game_over outside PLAY, and triggers outside IDLE.
- Simultaneous events: game_over and frame_tick in the same cycle in PLAY means OVER with counter = 0 (the tick is not counted).
- Mid-operation reset: reset_n from any state returns all outputs to reset values on the next clock.
- Mode changes: game_mode_chosen changes after acceptance have no effect until the next IDLE.
- Latency: trigger edge to menu_active = 0 is 1 clock.

Optional Feature:
- PAUSE_EN defined:
  - In PLAY, a rising edge of pause_btn toggles game_paused. While paused, game_active = 0, hexout2 shows blank, and game_over is still honoured.
  - Leaving PLAY clears game_paused.
- PAUSE_EN undefined: pause_btn is unused and game_paused is tied to 0.

Decomposition:
- Shared package game_pkg holds:
  - state typedef: IDLE, COUNT, FIGHT, PLAY, OVER.
  - seven-segment constants: SEG_0..SEG_3, SEG_F, SEG_P, SEG_BLANK.
- Natural sub-module: edge_detect_rise (1-bit registered rising-edge detector). It is instantiated for trigger_count_start and pause_btn; its history register resets to 1.

Test Plan (COUNT_FRAMES=4, FIGHT_FRAMES=2, OVER_FRAMES=3, frame_tick every 2 clocks):
- Reset with trigger held high, then release and re-press with mode=1 -> no start while held; after the re-press, menu_active = 0 and mode_latched = 1 one clock after the edge.
- Full countdown -> hexout steps 0110000, 0100100, 1111001 (4 ticks each), then 0001110 for 2 ticks, then PLAY with hexout = 0100100 and hexout2 = 0001100.
- Toggle game_mode_chosen during COUNT -> mode_latched and the PLAY digit are unchanged.
- game_over pulse in PLAY coincident with frame_tick -> OVER next clock, digits blank, IDLE after exactly 3 ticks, menu_active = 1.
- Assert reset_n mid-COUNT with digit = 2 -> next clock shows state IDLE, blank digits, menu_active = 1.
- PAUSE_EN: press pause in PLAY -> game_paused = 1, game_active = 0; press again -> resumed; game_over while paused -> OVER with game_paused = 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and seven-segment constants for the game start sequencer.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    FIGHT = 3'd2,
    PLAY  = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decimal digit to active-low segment pattern; out-of-range values blank.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Registered 1-bit rising-edge detector. The history register resets to 1 so
// an input already high when reset releases is not reported as an edge.
module edge_detect_rise (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_rise
);

  logic r_hist;

  // Track the previous input level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hist <= 1'b1;
    end else begin
      r_hist <= i_din;
    end
  end

  assign o_rise = i_din & ~r_hist;

endmodule

// File: rtl/game_start_sequencer.sv
// Game start sequencer: accepts the menu start trigger, freezes the game mode,
// runs the 3-2-1 countdown, FIGHT banner, play phase and game-over hold, then
// returns control to the menu.
// Optional build macro: PAUSE_EN enables the pause toggle in PLAY.
module game_start_sequencer
  import game_pkg::*;
#(
  parameter int unsigned COUNT_FRAMES = 60,
  parameter int unsigned COUNT_START  = 3,
  parameter int unsigned FIGHT_FRAMES = 30,
  parameter int unsigned OVER_FRAMES  = 120,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       trigger_count_start,
  input  logic       game_mode_chosen,
  input  logic       game_over,
  input  logic       pause_btn,
  output logic       menu_active,
  output logic       game_active,
  output logic       mode_latched,
  output logic [2:0] seq_state,
  output logic [6:0] hexout,
  output logic [6:0] hexout2,
  output logic       game_paused
);

  localparam logic [CNT_W-1:0] COUNT_LAST  = CNT_W'(COUNT_FRAMES - 1);
  localparam logic [CNT_W-1:0] FIGHT_LAST  = CNT_W'(FIGHT_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_LAST   = CNT_W'(OVER_FRAMES - 1);
  localparam logic [3:0]       DIGIT_START = 4'(COUNT_START);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_digit;
  logic             r_mode;
  logic             w_trig_rise;
  logic             w_cnt_last;
  logic             w_paused;

  // The reset port is active-high despite its legacy name.
  edge_detect_rise u_trig_edge (
    .i_clk  (clock),
    .i_rst  (reset_n),
    .i_din  (trigger_count_start),
    .o_rise (w_trig_rise)
  );

`ifdef PAUSE_EN
  logic w_pause_rise;
  logic r_paused;

  edge_detect_rise u_pause_edge (
    .i_clk  (clock),
    .i_rst  (reset_n),
    .i_din  (pause_btn),
    .o_rise (w_pause_rise)
  );

  // Pause toggles only while staying in PLAY; any exit from PLAY clears it.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      r_paused <= 1'b0;
    end else if (r_state == PLAY && !game_over) begin
      r_paused <= r_paused ^ w_pause_rise;
    end else begin
      r_paused <= 1'b0;
    end
  end

  assign w_paused = r_paused;
`else
  logic w_pause_unused;

  assign w_pause_unused = pause_btn;
  assign w_paused       = 1'b0;
`endif

  // Select the terminal frame count for the current timed phase.
  always_comb begin
    w_cnt_last = 1'b0;
    case (r_state)
      COUNT:   w_cnt_last = (r_cnt == COUNT_LAST);
      FIGHT:   w_cnt_last = (r_cnt == FIGHT_LAST);
      OVER:    w_cnt_last = (r_cnt == OVER_LAST);
      default: w_cnt_last = 1'b0;
    endcase
  end

  // Sequencer state, frame counter, countdown digit and frozen mode.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_digit <= '0;
      r_mode  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_trig_rise) begin
            r_mode  <= game_mode_chosen;
            r_digit <= DIGIT_START;
            r_cnt   <= '0;
            r_state <= COUNT;
          end
        end
        COUNT: begin
          if (frame_tick) begin
            if (w_cnt_last) begin
              r_cnt <= '0;
              if (r_digit <= 4'd1) begin
                r_digit <= '0;
                r_state <= FIGHT;
              end else begin
                r_digit <= r_digit - 4'd1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        FIGHT: begin
          if (frame_tick) begin
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_state <= PLAY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        PLAY: begin
          // A coincident frame_tick is not counted: OVER starts from zero.
          if (game_over) begin
            r_cnt   <= '0;
            r_state <= OVER;
          end
        end
        OVER: begin
          if (frame_tick) begin
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Decode status flags and display digits from the registered state.
  always_comb begin
    menu_active = 1'b0;
    game_active = 1'b0;
    hexout      = SEG_BLANK;
    hexout2     = SEG_BLANK;
    case (r_state)
      IDLE: begin
        menu_active = 1'b1;
      end
      COUNT: begin
        hexout = seg_digit(r_digit);
      end
      FIGHT: begin
        hexout = SEG_F;
      end
      PLAY: begin
        game_active = ~w_paused;
        hexout      = r_mode ? SEG_2 : SEG_1;
        hexout2     = w_paused ? SEG_BLANK : SEG_P;
      end
      default: begin
        menu_active = 1'b0;
      end
    endcase
  end

  assign mode_latched = r_mode;
  assign seq_state    = r_state;
  assign game_paused  = w_paused;

endmodule
